// File: rtl/mant_scheduler.sv
// Round-robin scheduler for one shared maintenance unit across N_REQ subsystems.
// Due (interval-expired) requests outrank manual ones; start/done handshake with timeout.
module mant_lane #(
  parameter int INTERVAL = 200,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          gnt,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          due
);
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (run && !gnt && cnt != CW'(INTERVAL))
      cnt_nxt = cnt + 1'b1;
  end

  // due tracks the next count so it always matches the current op count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      due <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      due <= (cnt_nxt == CW'(INTERVAL));
    end
  end
endmodule

module mant_scheduler #(
  parameter int N_REQ       = 4,
  parameter int INTERVAL    = 200,
  parameter int SVC_TIMEOUT = 32,
  parameter int CW          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         run,
  input  logic [N_REQ-1:0]         req,
  input  logic                     svc_done,
  input  logic                     err_clr,
  output logic [N_REQ-1:0]         gnt,
  output logic                     start,
  output logic [$clog2(N_REQ)-1:0] cur_id,
  output logic                     done,
  output logic [N_REQ-1:0]         due,
  output logic                     err
);
  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(SVC_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SERVICE, S_DONE, S_ERROR} state_t;

  state_t                     state;
  logic [N_REQ-1:0][CW-1:0]   op_cnt;
  logic [N_REQ-1:0]           clr;
  logic [N_REQ-1:0]           pend;
  logic [IDW-1:0]             rr_ptr;
  logic [IDW-1:0]             win;
  logic                       hit;
  logic [TW-1:0]              timer;
  logic                       busy;

  assign busy  = (state == S_GRANT) || (state == S_SERVICE);
  assign start = (state == S_GRANT);
  assign done  = (state == S_DONE);
  assign err   = (state == S_ERROR);
  assign pend  = (due != '0) ? due : req;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign gnt[i] = busy && (cur_id == IDW'(i));
    assign clr[i] = (state == S_SERVICE) && svc_done && (cur_id == IDW'(i));
    mant_lane #(.INTERVAL(INTERVAL), .CW(CW)) u_lane (
      .clk (clk),
      .rst (rst),
      .run (run[i]),
      .gnt (gnt[i]),
      .clr (clr[i]),
      .cnt (op_cnt[i]),
      .due (due[i])
    );
  end

  // first pending bit at or after rr_ptr, wrapping
  always_comb begin
    int j;
    j   = 0;
    win = '0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!hit && pend[j]) begin
        hit = 1'b1;
        win = IDW'(j);
      end
    end
  end

  // timer counts cycles since start (0 in the GRANT cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cur_id <= '0;
      rr_ptr <= '0;
      timer  <= '0;
    end else begin
      case (state)
        S_IDLE: if (hit) begin
          cur_id <= win;
          timer  <= '0;
          state  <= S_GRANT;
        end
        S_GRANT: begin
          timer <= timer + 1'b1;
          state <= S_SERVICE;
        end
        S_SERVICE: begin
          timer <= timer + 1'b1;
          if (svc_done) begin
            state  <= S_DONE;
            rr_ptr <= (cur_id == IDW'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
          end else if (timer == TW'(SVC_TIMEOUT - 1)) begin
            state <= S_ERROR;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: if (err_clr) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mant_scheduler.md
Name: mant_scheduler

Overview:
Schedules a single shared maintenance unit among N_REQ machine subsystems. Each subsystem raises maintenance either manually (req) or automatically once its operating-cycle count reaches INTERVAL (due). The scheduler arbitrates round-robin, with due requests ranked above manual ones, and hands the unit a start/done handshake with a timeout. It raises a sticky error on timeout and sits between the subsystem FSMs and the maintenance counter/message mux path.

Parameters:
N_REQ, 4, number of requesting subsystems (2..8)
INTERVAL, 200, operating cycles after which a subsystem becomes due
SVC_TIMEOUT, 32, max cycles from start to svc_done before error
CW, 8, width of per-subsystem operating counters (2^CW-1 >= INTERVAL)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
run  in  N_REQ  run[i]=1: subsystem i operating this cycle
req  in  N_REQ  manual maintenance request, level; sampled only in IDLE
svc_done  in  1  maintenance unit finished (1-cycle pulse)
err_clr  in  1  clears ERROR state (pulse)
gnt  out  N_REQ  one-hot grant, held from GRANT through SERVICE
start  out  1  1-cycle pulse to maintenance unit
cur_id  out  $clog2(N_REQ)  index of granted subsystem, valid while gnt!=0
done  out  1  1-cycle pulse when service completes normally
due  out  N_REQ  due[i]=1 when op_cnt[i]==INTERVAL
err  out  1  high while in ERROR

Behaviour:
- Reset: state IDLE; all op_cnt=0; rr_ptr=0; gnt=0, start=0, cur_id=0, done=0, due=0, err=0.
- op_cnt[i]: increments +1 per cycle when run[i]=1 and gnt[i]=0. Saturates at INTERVAL, never wraps. Cleared to 0 in the cycle DONE is entered for i. due[i] is registered and equals (op_cnt[i]==INTERVAL).
- Pending set: P = due when due!=0, else req. Due always preempts manual requests at selection time. No preemption of a service already in progress.
- Round-robin: search P starting at rr_ptr, ascending and wrapping modulo N_REQ. The first set bit wins. rr_ptr <= winner+1 (mod N_REQ) on entering DONE.
- FSM:
  IDLE: gnt=0. If P!=0, latch winner into cur_id -> GRANT, else stay.
  GRANT (1 cycle): gnt[cur_id]=1, start=1, timer=0 -> SERVICE.
  SERVICE: gnt held; timer+1 each cycle. svc_done=1 -> DONE. Else if timer==SVC_TIMEOUT-1 -> ERROR. svc_done in the same cycle as the timeout wins (-> DONE).
  DONE (1 cycle): done=1, gnt=0, op_cnt[cur_id] cleared -> IDLE.
  ERROR: err=1, gnt=0; op_cnt[cur_id] not cleared. err_clr=1 -> IDLE; stays otherwise.
- Latency: P set in IDLE -> start asserted on the 2nd rising edge (IDLE evaluates, GRANT registers). Minimum request-to-done is 4 cycles with immediate svc_done.
- svc_done outside SERVICE is ignored. err_clr outside ERROR is ignored.
- req[i] deasserted during GRANT/SERVICE: service continues to completion.
- Outputs gnt/start/done/err decode from the registered state (glitch-free). cur_id is registered.
- rst asserted mid-operation: immediate return to the reset values above, with no done pulse.

Test Plan:
- Reset/idle (INTERVAL=20, SVC_TIMEOUT=16): assert rst with all inputs 0 -> all outputs 0; after release, idle 50 cycles -> no gnt, no start.
- Manual single: req=4'b0100, svc_done 3 cycles after start -> gnt=0100 and cur_id=2; start pulse 2 edges after req; done 1 cycle after svc_done; rr_ptr=3.
- Round-robin: req=4'b1111 held, svc_done 2 cycles after each start -> grant order 0,1,2,3,0; exactly one done per grant.
- Due priority: run[1]=1 for 20 cycles -> due=0010. With req=4'b0001 also pending, next grant goes to 1. After done, op_cnt[1]=0 and due=0. op_cnt[1] does not increment while gnt[1]=1.
- Timeout: req=0001, svc_done never -> err=1 exactly 16 cycles after start; gnt=0; due unchanged. Later svc_done ignored; err_clr -> IDLE, then subsystem 0 is re-granted.
- Boundary: svc_done coincident with the timeout cycle -> done=1, err stays 0. rst mid-SERVICE -> gnt=0 and op_cnt=0 immediately, no done pulse.
